// File: rtl/data_sync_fifo_if.sv
// Bus-side bundle for data_sync_fifo: source data/qualifier/ack and the
// destination valid/ready stream with the per-event pulse.
interface data_sync_fifo_if #(
    parameter int unsigned BUS_WIDTH = 8
);
    logic [BUS_WIDTH-1:0] unsync_bus;
    logic                 bus_enable;
    logic                 ack;
    logic [BUS_WIDTH-1:0] sync_bus;
    logic                 sync_valid;
    logic                 sync_ready;
    logic                 enable_pulse;

    modport master (
        output unsync_bus,
        output bus_enable,
        output sync_ready,
        input  ack,
        input  sync_bus,
        input  sync_valid,
        input  enable_pulse
    );

    modport slave (
        input  unsync_bus,
        input  bus_enable,
        input  sync_ready,
        output ack,
        output sync_bus,
        output sync_valid,
        output enable_pulse
    );
endinterface

// File: rtl/data_sync_fifo.sv
// Multi-flop qualifier synchroniser with event capture into a small FIFO.
// Optional sticky drop flag enabled by defining DSYNC_OVERRUN_EN.
module data_sync_fifo #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned EN_MODE    = 0
) (
    input  logic                   CLK,
    input  logic                   RST,
    data_sync_fifo_if.slave        bus
`ifdef DSYNC_OVERRUN_EN
    ,
    output logic                   overrun,
    input  logic                   overrun_clr
`endif
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [NUM_STAGES-1:0] sync_chain;
    logic                  en_q;
    logic                  sync_last;
    logic                  event_det;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  pulse_q;

    logic [BUS_WIDTH-1:0]  mem [FIFO_DEPTH];

    // Qualifier synchroniser; en_q is one stage past the chain for edge detect.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_chain <= '0;
            en_q       <= 1'b0;
        end else begin
            sync_chain <= {sync_chain[NUM_STAGES-2:0], bus.bus_enable};
            en_q       <= sync_last;
        end
    end

    assign sync_last = sync_chain[NUM_STAGES-1];

    generate
        if (EN_MODE == 0) begin : g_level
            assign event_det = sync_last & ~en_q;
        end else begin : g_toggle
            assign event_det = sync_last ^ en_q;
        end
    endgenerate

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = ~empty & bus.sync_ready;
    // A full queue still takes the new word if the head leaves this cycle.
    assign push  = event_det & (~full | pop);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pulse_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            pulse_q <= event_det;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.unsync_bus;
        end
    end

    always_comb begin
        bus.sync_bus = '0;
        if (!empty) begin
            bus.sync_bus = mem[rd_ptr[AW-1:0]];
        end
    end

    assign bus.sync_valid   = ~empty;
    assign bus.enable_pulse = pulse_q;
    assign bus.ack          = en_q;

`ifdef DSYNC_OVERRUN_EN
    logic drop;

    assign drop = event_det & full & ~pop;

    // Set wins over a coincident clear so no drop goes unreported.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule
